rvfi_retire_queue: RTL
======================

RVFI_RETIRE_QUEUE -- requirements
Module: rvfi_retire_queue

Interface
REQ-001 SHALL have parameter PKT_W, default 160, width of opaque retired-instruction packet (insn, pc, rd, mem fields packed by integrator).
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..64.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  core retires one instruction this cycle (RVFI valid).
REQ-006 SHALL have port in_pkt  input  PKT_W  retired-instruction packet.
REQ-007 SHALL have port in_order  input  64  RVFI order number of in_pkt.
REQ-008 SHALL have port in_ready  output  1  queue not full (informative; RVFI cannot stall).
REQ-009 SHALL have port out_valid  output  1  head entry available to the checker.
REQ-010 SHALL have port out_ready  input  1  checker consumes head entry.
REQ-011 SHALL have port out_pkt  output  PKT_W  head packet.
REQ-012 SHALL have port out_order  output  64  head order number.
REQ-013 SHALL have port check_order  input  64  order number on which the checker fires.
REQ-014 SHALL have port out_check  output  1  head beat is the instruction under check.
REQ-015 SHALL have port overflow  output  1  sticky: a retire was dropped.
REQ-016 SHALL have port order_err  output  1  sticky: non-contiguous order seen.
REQ-017 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-018 SHALL store packets in FIFO order in a DEPTH-entry circular buffer; read/write pointers wrap modulo DEPTH.
REQ-019 SHALL accept a push when in_valid && in_ready; entry visible on out_* the following cycle (latency 1, no combinational bypass).
REQ-020 SHALL pop when out_valid && out_ready; next entry on out_* the following cycle.
REQ-021 in_ready SHALL equal (level != DEPTH); out_valid SHALL equal (level != 0).
REQ-022 Push and pop in the same cycle SHALL leave level unchanged; when full, in_ready=0 even if pop occurs (no same-cycle slot reuse).
REQ-023 in_valid while full SHALL drop the packet, not modify queue, and set overflow the next cycle.
REQ-024 out_check SHALL equal out_valid && (out_order == check_order), combinational.
REQ-025 out_pkt/out_order SHALL hold stable while out_valid && !out_ready.
REQ-026 overflow and order_err SHALL clear only on reset.

Reset
REQ-027 On reset low at a rising edge: pointers=0, level=0, out_valid=0, in_ready=1, overflow=0, order_err=0, order tracker idle; queued entries discarded.
REQ-028 Reset asserted mid-operation SHALL take priority over simultaneous push/pop in that cycle.
REQ-029 Storage contents need not be reset; out_pkt/out_order are don't-care while out_valid=0.

Configuration
REQ-030 Macro RVFI_RETIRE_QUEUE_ORDER_CHECK_EN SHALL enable order tracking: first accepted push after reset loads expected=in_order+1; each later accepted push with in_order != expected sets order_err next cycle; expected always reloads to in_order+1.
REQ-031 Without RVFI_RETIRE_QUEUE_ORDER_CHECK_EN, order_err SHALL be tied 0 and no tracking state SHALL exist.
REQ-032 Dropped (overflow) pushes SHALL NOT update the order tracker.

Verification
REQ-033 Push orders 0,1,2 on consecutive cycles, out_ready=1 -> out_order 0,1,2 on cycles 1,2,3; level max 1; no flags.
REQ-034 DEPTH=4, out_ready=0, push 5 packets -> in_ready=0 after 4th, 5th dropped, overflow=1, level=4; drain yields orders 0..3.
REQ-035 Full queue, push+pop same cycle -> push dropped, overflow=1, level=3.
REQ-036 check_order=7, stream orders 5..9 -> out_check high only on beat with out_order=7.
REQ-037 With ORDER_CHECK_EN, push orders 10,11,13 -> order_err=1 cycle after 13 accepted; without macro order_err stays 0.
REQ-038 Queue level 3, reset=0 one cycle with in_valid=1 -> level=0, out_valid=0, flags 0 next cycle.

Source files
------------

// File: rtl/rvfi_retire_queue_if.sv
// Handshake bundle between the RVFI retire port, the retire queue and the formal checker.
// master = integrator/checker side, slave = the queue itself.
interface rvfi_retire_queue_if #(
    parameter int PKT_W = 160,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [PKT_W-1:0] in_pkt;
    logic [63:0]      in_order;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [PKT_W-1:0] out_pkt;
    logic [63:0]      out_order;
    logic [63:0]      check_order;
    logic             out_check;
    logic             overflow;
    logic             order_err;
    logic [LW-1:0]    level;

    modport master (
        output in_valid, in_pkt, in_order, out_ready, check_order,
        input  in_ready, out_valid, out_pkt, out_order, out_check, overflow, order_err, level
    );

    modport slave (
        input  in_valid, in_pkt, in_order, out_ready, check_order,
        output in_ready, out_valid, out_pkt, out_order, out_check, overflow, order_err, level
    );
endinterface

// File: rtl/rvfi_retire_queue.sv
// FIFO decoupling RVFI retirement from a formal checker; drops and flags retires when full.
// Optional order-contiguity tracking is enabled with `define RVFI_RETIRE_QUEUE_ORDER_CHECK_EN.
module rvfi_retire_queue #(
    parameter int PKT_W = 160,
    parameter int DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    rvfi_retire_queue_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = PKT_W + 64;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head_reg;
    logic [EW-1:0] wr_data;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [LW-1:0] level_reg;
    logic          overflow_reg;
    logic          in_ready_w;
    logic          out_valid_w;
    logic          push;
    logic          pop;

    assign in_ready_w  = (level_reg != LW'(DEPTH));
    assign out_valid_w = (level_reg != '0);
    assign push        = bus.in_valid && in_ready_w;
    assign pop         = out_valid_w && bus.out_ready;
    assign wr_data     = {bus.in_order, bus.in_pkt};
    assign rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Registered head read; forward the incoming entry when it lands on the slot read next.
    always_ff @(posedge clock) begin
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= wr_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
            if (bus.in_valid && !in_ready_w) begin
                overflow_reg <= 1'b1;
            end
        end
    end

`ifdef RVFI_RETIRE_QUEUE_ORDER_CHECK_EN
    logic [63:0] expected_reg;
    logic        tracking_reg;
    logic        order_err_reg;

    // Only accepted pushes feed the tracker, so dropped retires never disturb it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            expected_reg  <= '0;
            tracking_reg  <= 1'b0;
            order_err_reg <= 1'b0;
        end else if (push) begin
            tracking_reg <= 1'b1;
            expected_reg <= bus.in_order + 64'd1;
            if (tracking_reg && (bus.in_order != expected_reg)) begin
                order_err_reg <= 1'b1;
            end
        end
    end

    assign bus.order_err = order_err_reg;
`else
    assign bus.order_err = 1'b0;
`endif

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_pkt   = head_reg[PKT_W-1:0];
    assign bus.out_order = head_reg[EW-1:PKT_W];
    assign bus.out_check = out_valid_w && (head_reg[EW-1:PKT_W] == bus.check_order);
    assign bus.overflow  = overflow_reg;
    assign bus.level     = level_reg;
endmodule
